// File: rtl/imm_encode_rv32i.sv
// imm_encode_rv32i
//
// Purpose:
//    Packs a 32-bit signed immediate into the RV32I immediate bit positions
//    instr[31:7] for the I, S, B, U and J formats. It also reports illegal
//    format codes and keeps a saturating count of erroneous results.
//    Each request takes three cycles:
//      IDLE  accepts the request,
//      CHECK computes and registers the encoding,
//      DONE  presents the result until the consumer takes it.
//
// Ports:
//    clk            in   1   clock, all state updates on the rising edge
//    rst            in   1   synchronous active-high reset
//    in_valid       in   1   request present
//    in_ready       out  1   high only in IDLE
//    in_imm         in  32   immediate to encode
//    in_immtype     in   3   000 I, 001 S, 010 B, 011 U, 100 J, others illegal
//    out_valid      out  1   result present (DONE state)
//    out_ready      in   1   consumer accepts the result
//    trimmed_instr  out 25   immediate bits placed at instr[31:7]
//    imm_mask       out 25   marks which trimmed_instr bits are immediate bits
//    out_err        out  1   illegal type, or immediate out of range
//    err_cnt        out  8   saturating count of delivered errored results
//
// Configuration:
//    IMM_ENCODE_RANGECHK_EN - when defined, immediates that do not fit their
//    format (or are misaligned for B/J) are flagged as errors.
//    When it is not defined, these immediates are silently truncated.

module imm_encode_rv32i (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_immtype,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] trimmed_instr,
    output logic [24:0] imm_mask,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] TYPE_I = 3'd0;
    localparam logic [2:0] TYPE_S = 3'd1;
    localparam logic [2:0] TYPE_B = 3'd2;
    localparam logic [2:0] TYPE_U = 3'd3;
    localparam logic [2:0] TYPE_J = 3'd4;

    logic [1:0]  r_state;
    logic [31:0] r_imm;
    logic [2:0]  r_type;
    logic [24:0] r_trim;
    logic [24:0] r_mask;
    logic        r_err;
    logic [7:0]  r_errCnt;

    logic [24:0] w_trimRaw;
    logic [24:0] w_maskRaw;
    logic        w_legal;
    logic        w_rangeBad;
    logic        w_err;

    // Raw field placement for the captured request.
    // An illegal type produces no field bits at all.
    always_comb begin
        w_trimRaw = '0;
        w_maskRaw = '0;
        w_legal   = 1'b1;
        case (r_type)
            TYPE_I: begin
                w_trimRaw[24:13] = r_imm[11:0];
                w_maskRaw[24:13] = '1;
            end
            TYPE_S: begin
                w_trimRaw[24:18] = r_imm[11:5];
                w_trimRaw[4:0]   = r_imm[4:0];
                w_maskRaw[24:18] = '1;
                w_maskRaw[4:0]   = '1;
            end
            TYPE_B: begin
                w_trimRaw[24]    = r_imm[12];
                w_trimRaw[23:18] = r_imm[10:5];
                w_trimRaw[4:1]   = r_imm[4:1];
                w_trimRaw[0]     = r_imm[11];
                w_maskRaw[24:18] = '1;
                w_maskRaw[4:0]   = '1;
            end
            TYPE_U: begin
                w_trimRaw[24:5] = r_imm[31:12];
                w_maskRaw[24:5] = '1;
            end
            TYPE_J: begin
                w_trimRaw[24]    = r_imm[20];
                w_trimRaw[23:14] = r_imm[10:1];
                w_trimRaw[13]    = r_imm[11];
                w_trimRaw[12:5]  = r_imm[19:12];
                w_maskRaw[24:5]  = '1;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

`ifdef IMM_ENCODE_RANGECHK_EN
    // An immediate fits its format when every bit above the top encoded bit
    // is a copy of the sign bit. B and J immediates must also be even.
    always_comb begin
        w_rangeBad = 1'b0;
        case (r_type)
            TYPE_I, TYPE_S: w_rangeBad = (r_imm[31:11] != {21{r_imm[31]}});
            TYPE_B:         w_rangeBad = (r_imm[31:12] != {20{r_imm[31]}}) || r_imm[0];
            TYPE_U:         w_rangeBad = (r_imm[11:0] != 12'd0);
            TYPE_J:         w_rangeBad = (r_imm[31:20] != {12{r_imm[31]}}) || r_imm[0];
            default:        w_rangeBad = 1'b0;
        endcase
    end
`else
    assign w_rangeBad = 1'b0;
`endif

    assign w_err = !w_legal || w_rangeBad;

    // Request/response sequencing.
    // Reset wins over both handshakes in the same cycle.
    // The error counter only counts results that the consumer actually took.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_imm    <= '0;
            r_type   <= '0;
            r_trim   <= '0;
            r_mask   <= '0;
            r_err    <= 1'b0;
            r_errCnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_imm   <= in_imm;
                        r_type  <= in_immtype;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_trim  <= w_err ? 25'd0 : w_trimRaw;
                    r_mask  <= w_err ? 25'd0 : w_maskRaw;
                    r_err   <= w_err;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                        if (r_err && (r_errCnt != 8'hFF)) begin
                            r_errCnt <= r_errCnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready      = (r_state == ST_IDLE);
    assign out_valid     = (r_state == ST_DONE);
    assign trimmed_instr = r_trim;
    assign imm_mask      = r_mask;
    assign out_err       = r_err;
    assign err_cnt       = r_errCnt;

endmodule

// File: tb/tb_imm_encode_rv32i.sv
// tb_imm_encode_rv32i
//
// Purpose:
//    Self-checking bench for imm_encode_rv32i.
//    The reference model places the immediate using a table of bit segments
//    per format. Range checks are done on the signed integer value.
//    Directed cases are followed by randomized requests.
//
// Configuration:
//    IMM_ENCODE_RANGECHK_EN - must match the define used for the RTL.

module tb_imm_encode_rv32i;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_imm;
    logic [2:0]  in_immtype;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] trimmed_instr;
    logic [24:0] imm_mask;
    logic        out_err;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad   = 0;
    int modelCnt = 0;

    logic [24:0] expTrim;
    logic [24:0] expMask;
    logic        expErr;

    imm_encode_rv32i dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_imm        (in_imm),
        .in_immtype    (in_immtype),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .trimmed_instr (trimmed_instr),
        .imm_mask      (imm_mask),
        .out_err       (out_err),
        .err_cnt       (err_cnt)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder.
    // Each format is a list of segments (destination low bit, source low bit, width).
    function automatic void modelEnc(input logic [2:0] t, input logic [31:0] imm,
                                     output logic [24:0] trim, output logic [24:0] mask,
                                     output logic err);
        int seg[4][3];
        int nSeg;
        int s;
        logic rangeBad;
        s = int'($signed(imm));
        rangeBad = 1'b0;
        nSeg = 0;
        trim = '0;
        mask = '0;
        err  = 1'b0;
        case (t)
            3'd0: begin seg[0] = '{13, 0, 12}; nSeg = 1;
                        rangeBad = (s < -2048) || (s > 2047); end
            3'd1: begin seg[0] = '{18, 5, 7}; seg[1] = '{0, 0, 5}; nSeg = 2;
                        rangeBad = (s < -2048) || (s > 2047); end
            3'd2: begin seg[0] = '{24, 12, 1}; seg[1] = '{18, 5, 6};
                        seg[2] = '{1, 1, 4}; seg[3] = '{0, 11, 1}; nSeg = 4;
                        rangeBad = (s < -4096) || (s > 4095) || (s % 2 != 0); end
            3'd3: begin seg[0] = '{5, 12, 20}; nSeg = 1;
                        rangeBad = (imm % 4096) != 0; end
            3'd4: begin seg[0] = '{24, 20, 1}; seg[1] = '{14, 1, 10};
                        seg[2] = '{13, 11, 1}; seg[3] = '{5, 12, 8}; nSeg = 4;
                        rangeBad = (s < -1048576) || (s > 1048575) || (s % 2 != 0); end
            default: err = 1'b1;
        endcase
`ifdef IMM_ENCODE_RANGECHK_EN
        if (rangeBad) err = 1'b1;
`endif
        if (!err) begin
            for (int g = 0; g < nSeg; g++) begin
                for (int k = 0; k < seg[g][2]; k++) begin
                    trim[seg[g][0] + k] = imm[seg[g][1] + k];
                    mask[seg[g][0] + k] = 1'b1;
                end
            end
        end
    endfunction

    // Send one request and bring it to the DONE state.
    // While the result is held, in_valid is asserted with junk values; it must be ignored.
    task automatic applyStimulus(input logic [2:0] t, input logic [31:0] imm, input int holdCycles);
        int waitCnt;
        waitCnt = 0;
        while (!in_ready && waitCnt < 20) begin
            tick();
            waitCnt++;
        end
        checkVal("in_ready_idle", in_ready, 1);
        modelEnc(t, imm, expTrim, expMask, expErr);
        in_valid   = 1'b1;
        in_imm     = imm;
        in_immtype = t;
        tick();
        in_valid   = 1'b0;
        in_imm     = $urandom;
        in_immtype = 3'($urandom);
        checkVal("out_valid_check_state", out_valid, 0);
        checkVal("in_ready_check_state", in_ready, 0);
        tick();
        checkVal("out_valid_done", out_valid, 1);
        for (int h = 0; h < holdCycles; h++) begin
            in_valid   = 1'b1;
            in_imm     = $urandom;
            in_immtype = 3'($urandom);
            tick();
            checkVal("hold_out_valid", out_valid, 1);
            checkVal("hold_in_ready", in_ready, 0);
            checkVal("hold_trim", trimmed_instr, expTrim);
        end
        in_valid = 1'b0;
    endtask

    // Compare the presented result against the model, then take it.
    task automatic checkOutput();
        checkVal("trimmed_instr", trimmed_instr, expTrim);
        checkVal("imm_mask", imm_mask, expMask);
        checkVal("out_err", out_err, expErr);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (expErr && modelCnt < 255) modelCnt++;
        checkVal("err_cnt", err_cnt, modelCnt);
        checkVal("in_ready_after", in_ready, 1);
        checkVal("out_valid_after", out_valid, 0);
    endtask

    initial begin
        logic [31:0] imm;
        logic [2:0]  t;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_imm     = '0;
        in_immtype = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        checkVal("rst_out_valid", out_valid, 0);
        checkVal("rst_trim", trimmed_instr, 0);
        checkVal("rst_mask", imm_mask, 0);
        checkVal("rst_err", out_err, 0);
        checkVal("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        tick();
        checkVal("rst_in_ready", in_ready, 1);

        // Directed cases with spec-derived constants.
        applyStimulus(3'd0, 32'hFFFF_FFFF, 0);
        checkVal("I_all_ones_trim", trimmed_instr, 32'h1FF_E000);
        checkVal("I_all_ones_mask", imm_mask, 32'h1FF_E000);
        checkVal("I_all_ones_err", out_err, 0);
        checkOutput();

        applyStimulus(3'd2, 32'h0000_0800, 0);
        checkVal("B_800_trim", trimmed_instr, 32'h000_0001);
        checkVal("B_800_mask", imm_mask, 32'h1FC_001F);
        checkOutput();

        applyStimulus(3'd4, 32'h0000_0002, 0);
        checkVal("J_2_trim", trimmed_instr, 32'h000_4000);
        checkOutput();

        applyStimulus(3'd3, 32'h1234_5000, 3);
        checkVal("U_hold_trim", trimmed_instr, 32'h024_68A0);
        checkOutput();

        applyStimulus(3'd0, 32'h0000_0800, 0);
`ifdef IMM_ENCODE_RANGECHK_EN
        checkVal("I_800_err", out_err, 1);
        checkVal("I_800_trim", trimmed_instr, 0);
        checkOutput();
        checkVal("I_800_cnt", err_cnt, 1);
`else
        checkVal("I_800_err", out_err, 0);
        checkVal("I_800_trim", trimmed_instr, 32'h100_0000);
        checkOutput();
`endif

        // Make sure err_cnt is nonzero, then reset while in DONE with out_ready high.
        applyStimulus(3'd7, 32'h0000_0000, 0);
        checkOutput();
        applyStimulus(3'd5, 32'h0000_0004, 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        modelCnt  = 0;
        checkVal("rst_done_out_valid", out_valid, 0);
        checkVal("rst_done_err_cnt", err_cnt, 0);
        checkVal("rst_done_in_ready", in_ready, 1);
        applyStimulus(3'd1, 32'hFFFF_F803, 1);
        checkOutput();

        // Reset must win over an input handshake in the same cycle.
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_immtype = 3'd0;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checkVal("rst_prio_in_ready", in_ready, 1);
        tick();
        checkVal("rst_prio_out_valid", out_valid, 0);

        // Randomized requests, biased toward range boundaries.
        for (int n = 0; n < 80; n++) begin
            t = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
                default: imm = {$urandom_range(0, 1048575), 12'd0};
            endcase
            applyStimulus(t, imm, $urandom_range(0, 2));
            checkOutput();
        end

        // Illegal type repeated to drive the counter into saturation.
        for (int n = 0; n < 260; n++) begin
            applyStimulus(3'd7, $urandom, 0);
            checkOutput();
        end
        checkVal("err_cnt_saturated", err_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_encode_rv32i.md
IMM_ENCODE_RV32I -- requirements
Module: imm_encode_rv32i

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have ports: in_valid  in  1  request present.
REQ-004 SHALL have ports: in_ready  out  1  block can accept a request.
REQ-005 SHALL have ports: in_imm  in  32  signed immediate value to encode.
REQ-006 SHALL have ports: in_immtype  in  3  000 I, 001 S, 010 B, 011 U, 100 J; 101-111 illegal.
REQ-007 SHALL have ports: out_valid  out  1  encoded result present.
REQ-008 SHALL have ports: out_ready  in  1  consumer accepts result.
REQ-009 SHALL have ports: trimmed_instr  out  25  encoded immediate field bits, mapped to instr[31:7].
REQ-010 SHALL have ports: imm_mask  out  25  1 where trimmed_instr bit belongs to the immediate field.
REQ-011 SHALL have ports: out_err  out  1  request illegal or immediate not encodable.
REQ-012 SHALL have ports: err_cnt  out  8  saturating count of results delivered with out_err=1.

Function
REQ-013 SHALL implement FSM IDLE -> CHECK -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-014 SHALL register in_imm/in_immtype on handshake (in_valid & in_ready) and move IDLE->CHECK.
REQ-015 SHALL compute encoding and error in CHECK, register them, and move to DONE unconditionally.
REQ-016 SHALL assert out_valid in DONE only; result appears 2 cycles after accepting handshake.
REQ-017 SHALL hold trimmed_instr, imm_mask and out_err stable while out_valid=1 and out_ready=0.
REQ-018 SHALL return DONE->IDLE on out_valid & out_ready; in_ready rises the following cycle (max one request per 3 cycles).
REQ-019 SHALL pack I: [24:13]=imm[11:0]; mask [24:13].
REQ-020 SHALL pack S: [24:18]=imm[11:5], [4:0]=imm[4:0]; mask [24:18],[4:0].
REQ-021 SHALL pack B: [24]=imm[12], [23:18]=imm[10:5], [4:1]=imm[4:1], [0]=imm[11]; mask as S.
REQ-022 SHALL pack U: [24:5]=imm[31:12]; mask [24:5].
REQ-023 SHALL pack J: [24]=imm[20], [23:14]=imm[10:1], [13]=imm[11], [12:5]=imm[19:12]; mask [24:5].
REQ-024 SHALL drive all trimmed_instr bits outside imm_mask to 0.
REQ-025 SHALL, for illegal in_immtype, set out_err=1, trimmed_instr=0, imm_mask=0, regardless of configuration.
REQ-026 SHALL increment err_cnt by 1 at each output handshake with out_err=1, saturating at 255 (no wrap).
REQ-027 SHALL ignore in_valid outside IDLE (no queuing, no side effects).

Reset
REQ-028 SHALL on rst force state IDLE, out_valid=0, out_err=0, trimmed_instr=0, imm_mask=0, err_cnt=0.
REQ-029 SHALL, on rst mid-transaction (CHECK or DONE), discard the transaction with no output handshake; in_ready=1 the cycle after rst deasserts.
REQ-030 SHALL give rst priority over any simultaneous handshake in the same cycle.

Configuration
REQ-031 SHALL use macro IMM_ENCODE_RANGECHK_EN to compile in range/alignment checking.
REQ-032 SHALL, with macro defined, set out_err=1 (trimmed_instr=0, imm_mask=0) when: I/S imm[31:11] not all equal; B imm[31:12] not all equal or imm[0]=1; U imm[11:0]!=0; J imm[31:20] not all equal or imm[0]=1.
REQ-033 SHALL, without macro, silently truncate per REQ-019..023 with out_err=0 for legal types.

Verification
REQ-034 SHALL test I, imm=0xFFFFFFFF, out_ready=1 -> trimmed_instr=0x1FFE000, imm_mask=0x1FFE000, out_err=0, out_valid 2 cycles after accept.
REQ-035 SHALL test B, imm=0x00000800 -> trimmed_instr=0x0000001, imm_mask=0x1FC001F; J, imm=0x00000002 -> trimmed_instr=0x0004000.
REQ-036 SHALL test U, imm=0x12345000 with out_ready=0 for 3 cycles -> trimmed_instr=0x02468A0 held stable, out_valid held, in_ready=0 throughout.
REQ-037 SHALL test I, imm=0x00000800: macro defined -> out_err=1, trimmed_instr=0, err_cnt=1; undefined -> trimmed_instr=0x1000000, out_err=0.
REQ-038 SHALL test in_immtype=111 repeated 260 times -> out_err=1 each, err_cnt saturates at 255.
REQ-039 SHALL test rst asserted in DONE -> out_valid=0 next cycle, err_cnt=0, next request encoded correctly.
